// File: rtl/dcache_uncache_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : dcache_uncache_unit_if
// Description : Request/response and external bus signals for the uncached
//               data-side access engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface dcache_uncache_unit_if;
   logic        req_valid;
   logic        req_uncache;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_paddr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [1:0]  rd_size;
   logic        rd_rdy;
   logic        ret_valid;
   logic [31:0] ret_data;
   logic        wr_req;
   logic [31:0] wr_addr;
   logic [1:0]  wr_size;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_rdy;
   logic        wr_done;

   // Engine side: takes requests from the pipeline, drives the bus.
   modport slave (
      input  req_valid, req_uncache, req_we, req_paddr, req_size, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output rd_req, rd_addr, rd_size,
      input  rd_rdy, ret_valid, ret_data,
      output wr_req, wr_addr, wr_size, wr_data, wr_strb,
      input  wr_rdy, wr_done
   );

   // Pipeline + bus side.
   modport master (
      output req_valid, req_uncache, req_we, req_paddr, req_size, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  rd_req, rd_addr, rd_size,
      output rd_rdy, ret_valid, ret_data,
      input  wr_req, wr_addr, wr_size, wr_data, wr_strb,
      output wr_rdy, wr_done
   );
endinterface
`default_nettype wire

// File: rtl/dcache_uncache_unit.sv
`default_nettype none
// ============================================================================
// Module      : dcache_uncache_unit
// Description : Single-outstanding uncached read/write engine for the dcache.
//               Optional bus-wait timeout enabled by macro UNCACHE_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_uncache_unit #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   dcache_uncache_unit_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_REQ  = 3'd1,
      S_RD_WAIT = 3'd2,
      S_WR_REQ  = 3'd3,
      S_WR_WAIT = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [1:0]  r_size;
   logic [3:0]  r_wstrb;
   logic        r_err;
   logic        w_accept, w_capture, w_err_nxt, w_timeout;

   assign w_accept = bus.req_valid & bus.req_uncache & (r_state == S_IDLE);

`ifdef UNCACHE_TIMEOUT_EN
   logic [31:0] r_cnt;
   logic        w_busy;

   assign w_busy    = (r_state == S_RD_REQ) || (r_state == S_RD_WAIT) ||
                      (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
   // Fires on the TIMEOUT_CYCLES-th busy cycle, so the count reaches the limit on exit.
   assign w_timeout = w_busy && (r_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)           r_cnt <= '0;
      else if (w_accept) r_cnt <= '0;
      else if (w_busy)   r_cnt <= r_cnt + 32'd1;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_err_nxt   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = bus.req_we ? S_WR_REQ : S_RD_REQ;
         end
         S_RD_REQ: begin
            // Completion beats timeout; a bare handshake at the limit still aborts.
            if (bus.rd_rdy && bus.ret_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_RESP;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RESP;
            end else if (bus.rd_rdy) begin
               w_state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (bus.ret_valid) begin
               w_capture   = 1'b1;
               w_state_nxt = S_RESP;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_WR_REQ: begin
            if (bus.wr_rdy && bus.wr_done) begin
               w_state_nxt = S_RESP;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RESP;
            end else if (bus.wr_rdy) begin
               w_state_nxt = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (bus.wr_done) begin
               w_state_nxt = S_RESP;
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_size  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_err_nxt;
         if (w_accept) begin
            r_addr  <= bus.req_paddr;
            r_size  <= bus.req_size;
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
         end
         if (w_capture)      r_rdata <= bus.ret_data;
         else if (w_err_nxt) r_rdata <= '0;
      end
   end

   // Requests are gated by rst so an abandoned transaction leaves the bus at once.
   assign bus.rd_req     = (r_state == S_RD_REQ) & ~rst;
   assign bus.wr_req     = (r_state == S_WR_REQ) & ~rst;
   assign bus.req_ready  = (r_state == S_IDLE);
   assign bus.resp_valid = (r_state == S_RESP);
   assign bus.resp_err   = r_err;
   assign bus.resp_rdata = r_rdata;
   assign bus.rd_addr    = r_addr;
   assign bus.rd_size    = r_size;
   assign bus.wr_addr    = r_addr;
   assign bus.wr_size    = r_size;
   assign bus.wr_data    = r_wdata;
   assign bus.wr_strb    = r_wstrb;
endmodule
`default_nettype wire

// File: tb/tb_dcache_uncache_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_uncache_unit
// Description : Self-checking bench: vector table, corner sequences and
//               randomized transactions against a latency/data model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_uncache_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   dcache_uncache_unit_if u_if ();

   dcache_uncache_unit #(.TIMEOUT_CYCLES(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          d_rdy;     // cycles rdy is withheld after the request appears
      int          d_ret;     // cycles from rdy to ret_valid/wr_done (0 = same cycle)
      logic [31:0] rdata;     // expected read word
      int          exp_lat;   // cycles from accept to resp_valid
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      u_if.req_valid   = 1'b0;
      u_if.req_uncache = 1'b0;
      u_if.req_we      = 1'b0;
      u_if.req_paddr   = '0;
      u_if.req_size    = '0;
      u_if.req_wdata   = '0;
      u_if.req_wstrb   = '0;
      u_if.rd_rdy      = 1'b0;
      u_if.ret_valid   = 1'b0;
      u_if.ret_data    = '0;
      u_if.wr_rdy      = 1'b0;
      u_if.wr_done     = 1'b0;
   endtask

   task automatic accept(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
      idle_inputs();
      u_if.req_valid   = 1'b1;
      u_if.req_uncache = 1'b1;
      u_if.req_we      = we;
      u_if.req_paddr   = addr;
      u_if.req_size    = size;
      u_if.req_wdata   = wdata;
      u_if.req_wstrb   = wstrb;
      #1;
      chk("accept_ready", 32'(u_if.req_ready), 32'd1);
      cyc();
   endtask

   // Drives one transaction starting in an idle cycle; checks every cycle up to the response.
   task automatic run_txn(input string nm, input vec_t v);
      int rdy_k, fin_k;
      accept(v.we, v.addr, v.size, v.wdata, v.wstrb);
      rdy_k = 1 + v.d_rdy;
      fin_k = rdy_k + v.d_ret;
      for (int k = 1; k <= v.exp_lat; k++) begin
         idle_inputs();
         // Busy-time request noise must be ignored.
         u_if.req_valid   = 1'b1;
         u_if.req_uncache = 1'b1;
         u_if.req_we      = ~v.we;
         u_if.req_paddr   = $urandom;
         if (v.we) begin
            u_if.wr_rdy    = (k == rdy_k);
            u_if.wr_done   = (k == fin_k);
            u_if.rd_rdy    = 1'($urandom);
            u_if.ret_valid = 1'($urandom);
            u_if.ret_data  = $urandom;
         end else begin
            u_if.rd_rdy    = (k == rdy_k);
            u_if.ret_valid = (k == fin_k);
            u_if.ret_data  = (k == fin_k) ? v.rdata : $urandom;
            u_if.wr_rdy    = 1'($urandom);
            u_if.wr_done   = 1'($urandom);
         end
         #1;
         chk({nm, "_ready"}, 32'(u_if.req_ready), 32'd0);
         chk({nm, "_rd_req"}, 32'(u_if.rd_req), 32'(!v.we && k <= rdy_k));
         chk({nm, "_wr_req"}, 32'(u_if.wr_req), 32'(v.we && k <= rdy_k));
         chk({nm, "_resp_valid"}, 32'(u_if.resp_valid), 32'(k == v.exp_lat));
         if (k <= rdy_k) begin
            if (v.we) begin
               chk({nm, "_wr_addr"}, u_if.wr_addr, v.addr);
               chk({nm, "_wr_size"}, 32'(u_if.wr_size), 32'(v.size));
               chk({nm, "_wr_data"}, u_if.wr_data, v.wdata);
               chk({nm, "_wr_strb"}, 32'(u_if.wr_strb), 32'(v.wstrb));
            end else begin
               chk({nm, "_rd_addr"}, u_if.rd_addr, v.addr);
               chk({nm, "_rd_size"}, 32'(u_if.rd_size), 32'(v.size));
            end
         end
         if (k == v.exp_lat) begin
            chk({nm, "_resp_err"}, 32'(u_if.resp_err), 32'd0);
            if (!v.we) chk({nm, "_rdata"}, u_if.resp_rdata, v.rdata);
         end
         cyc();
      end
      idle_inputs();
   endtask

   vec_t tbl[5];
   vec_t rv;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1'b0, 32'hbfaf_fff0, 2'd2, 32'h0,         4'h0,    0, 1, 32'h0000_0041, 3};
      tbl[1] = '{1'b1, 32'hbfaf_fff0, 2'd0, 32'h0000_005A, 4'b0001, 3, 2, 32'h0,         7};
      tbl[2] = '{1'b1, 32'h1000_0002, 2'd1, 32'hBEEF_0000, 4'b1100, 0, 0, 32'h0,         2};
      tbl[3] = '{1'b0, 32'h1fc0_0004, 2'd1, 32'h0,         4'h0,    2, 3, 32'hCAFE_0000, 7};
      tbl[4] = '{1'b0, 32'hbfaf_0000, 2'd2, 32'h0,         4'h0,    0, 0, 32'h1234_5678, 2};

      // Reset state
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      chk("rst_rd_req", 32'(u_if.rd_req), 32'd0);
      chk("rst_wr_req", 32'(u_if.wr_req), 32'd0);
      chk("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
      chk("rst_resp_err", 32'(u_if.resp_err), 32'd0);
      chk("rst_resp_rdata", u_if.resp_rdata, 32'd0);
      chk("rst_rd_addr", u_if.rd_addr, 32'd0);
      chk("rst_wr_addr", u_if.wr_addr, 32'd0);
      rst = 1'b0;
      cyc();
      chk("post_rst_ready", 32'(u_if.req_ready), 32'd1);

      // Cached requests are not handshaken
      for (int k = 0; k < 5; k++) begin
         idle_inputs();
         u_if.req_valid = 1'b1;
         u_if.req_paddr = 32'hbfaf_fff0;
         #1;
         chk("cached_ready", 32'(u_if.req_ready), 32'd1);
         chk("cached_rd_req", 32'(u_if.rd_req), 32'd0);
         chk("cached_wr_req", 32'(u_if.wr_req), 32'd0);
         chk("cached_resp", 32'(u_if.resp_valid), 32'd0);
         cyc();
      end

      for (int i = 0; i < 5; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

      // Stray returns in IDLE leave the held read word alone
      for (int k = 0; k < 3; k++) begin
         idle_inputs();
         u_if.ret_valid = 1'b1;
         u_if.ret_data  = 32'hDEAD_BEEF;
         u_if.wr_done   = 1'b1;
         #1;
         chk("stray_resp", 32'(u_if.resp_valid), 32'd0);
         chk("stray_ready", 32'(u_if.req_ready), 32'd1);
         chk("stray_rdata", u_if.resp_rdata, 32'h1234_5678);
         cyc();
      end

      // Reset while in RD_WAIT, then a late return for the abandoned read
      accept(1'b0, 32'hbfaf_0010, 2'd2, 32'h0, 4'h0);
      idle_inputs();
      u_if.rd_rdy = 1'b1;
      cyc();
      idle_inputs();
      rst = 1'b1;
      #1;
      chk("rstw_rd_req", 32'(u_if.rd_req), 32'd0);
      cyc();
      rst = 1'b0;
      u_if.ret_valid = 1'b1;
      u_if.ret_data  = 32'h5555_AAAA;
      #1;
      chk("rstw_idle", 32'(u_if.req_ready), 32'd1);
      chk("rstw_resp", 32'(u_if.resp_valid), 32'd0);
      cyc();
      idle_inputs();
      #1;
      chk("rstw_resp2", 32'(u_if.resp_valid), 32'd0);
      chk("rstw_rdata", u_if.resp_rdata, 32'd0);
      run_txn("rstw_fresh", '{1'b0, 32'hbfaf_fff8, 2'd2, 32'h0, 4'h0, 1, 1, 32'h0000_0077, 4});

      // Reset while WR_REQ drops wr_req in the same cycle
      accept(1'b1, 32'hbfaf_fff4, 2'd2, 32'h1111_2222, 4'hF);
      idle_inputs();
      #1;
      chk("rstq_wr_req_before", 32'(u_if.wr_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstq_wr_req", 32'(u_if.wr_req), 32'd0);
      cyc();
      rst = 1'b0;
      #1;
      chk("rstq_idle", 32'(u_if.req_ready), 32'd1);

      // Randomized back-to-back transactions against the latency/data model
      for (int i = 0; i < 40; i++) begin
         rv.we      = 1'($urandom);
         rv.addr    = $urandom;
         rv.size    = 2'($urandom_range(0, 2));
         rv.wdata   = $urandom;
         rv.wstrb   = 4'($urandom);
         rv.d_rdy   = $urandom_range(0, 4);
         rv.d_ret   = $urandom_range(0, 3);
         rv.rdata   = $urandom;
         rv.exp_lat = 2 + rv.d_rdy + rv.d_ret;
         run_txn($sformatf("rnd%0d", i), rv);
      end

      // Read with rd_rdy never asserted
      accept(1'b0, 32'hbfaf_fff0, 2'd2, 32'h0, 4'h0);
`ifdef UNCACHE_TIMEOUT_EN
      for (int k = 1; k <= 9; k++) begin
         idle_inputs();
         #1;
         chk("to_rd_req", 32'(u_if.rd_req), 32'(k <= 8));
         chk("to_resp_valid", 32'(u_if.resp_valid), 32'(k == 9));
         chk("to_resp_err", 32'(u_if.resp_err), 32'(k == 9));
         if (k == 9) chk("to_rdata", u_if.resp_rdata, 32'd0);
         cyc();
      end
      #1;
      chk("to_ready", 32'(u_if.req_ready), 32'd1);
      chk("to_err_clear", 32'(u_if.resp_err), 32'd0);
`else
      for (int k = 1; k <= 100; k++) begin
         idle_inputs();
         #1;
         chk("nto_rd_req", 32'(u_if.rd_req), 32'd1);
         chk("nto_resp_valid", 32'(u_if.resp_valid), 32'd0);
         chk("nto_resp_err", 32'(u_if.resp_err), 32'd0);
         cyc();
      end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk("nto_ready", 32'(u_if.req_ready), 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
